// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory load/store unit:
// RV32I funct3 access sizes and the request FSM states.
package data_mem_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between a load/store master and data_mem_lsu.
interface data_mem_lsu_if;
  // A request transfers on a rising edge where req_valid and req_ready are both 1;
  // the master holds req_* stable while req_valid is 1 and req_ready is 0.
  // rsp_valid is a one-cycle strobe with no backpressure; rsp_rdata/rsp_err are 0 otherwise.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lane_align.sv
// Little-endian lane steering: byte enables, store replication, load
// extraction/extension and size/alignment fault detection.
module data_mem_lane_align
  import data_mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        fmt_err
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte     = rword[{lane, 3'b000} +: 8];
    rhalf     = lane[1] ? rword[31:16] : rword[15:0];
    be        = 4'b0000;
    wdata_rep = 32'h0;
    rdata     = 32'h0;
    fmt_err   = 1'b0;
    case (funct3)
      LSU_B: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{rbyte[7]}}, rbyte};
      end
      LSU_BU: begin
        rdata   = {24'h0, rbyte};
        fmt_err = we;
      end
      LSU_H: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{rhalf[15]}}, rhalf};
        fmt_err   = lane[0];
      end
      LSU_HU: begin
        rdata   = {16'h0, rhalf};
        fmt_err = we | lane[0];
      end
      LSU_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata     = rword;
        fmt_err   = (lane != 2'b00);
      end
      default: fmt_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Single-port data memory with an RV32I load/store front end and a fixed
// request-to-response latency; stores commit and loads sample at the accept edge.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_lsu_if.slave  bus,
  output lsu_state_e     state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WAIT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  logic [31:0]   mem [DEPTH];
  lsu_state_e    state;
  logic [2:0]    wait_cnt;
  logic          ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic [31:0]   rdata_hold;
  logic          err_hold;

  logic          accept;
  logic          range_err;
  logic          acc_err;
  logic          fmt_err;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [31:0]   ldata;

  // ready_q is only ever 1 in IDLE, so it alone qualifies the accept.
  assign accept    = bus.req_valid && ready_q;
  assign widx      = bus.req_addr[AW+1:2];
  assign range_err = |bus.req_addr[31:AW+2];
  assign acc_err   = range_err | fmt_err;

  data_mem_lane_align u_align (
    .we        (bus.req_we),
    .funct3    (bus.req_funct3),
    .lane      (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .rword     (mem[widx]),
    .be        (be),
    .wdata_rep (wrep),
    .rdata     (ldata),
    .fmt_err   (fmt_err)
  );

  // Storage is deliberately outside reset so committed stores survive it.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= 3'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rdata_hold  <= 32'h0;
      err_hold    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q    <= 1'b0;
            err_hold   <= acc_err;
            rdata_hold <= (acc_err || bus.req_we) ? 32'h0 : ldata;
            if (LATENCY > 1) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        ST_RESP: begin
          // The response strobe is registered out of RESP, landing LATENCY edges after accept.
          state       <= ST_IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rdata_hold;
          rsp_err_q   <= err_hold;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign state_dbg     = state;

endmodule
